dm_responder: RTL and testbench
===============================

// Module: dm_responder
// PURPOSE
//  Data-memory responder: the memory end of the CPU data interface (addr, wdata, write, DMType).
//  Replaces the zero-latency dm model with a handshaked, multi-cycle memory using configurable wait states.
//  Performs DMType-driven byte/half/word store merging and load sign/zero extension.
//  Flags misaligned, out-of-range and illegal-type accesses. Used with multi-cycle/pipelined SCPU variants.
// PARAMETERS
//  ADDR_WIDTH   7          word-address bits; array depth = 2**ADDR_WIDTH words of 32 bits
//  BASE_ADDR    32'h0      byte address of word 0; must be word-aligned
//  WAIT_CYCLES  2          extra wait states before access executes (0..15)
// PORTS
//  clk          in   1   clock; all state updates on the rising edge
//  rstn         in   1   synchronous, active-low reset
//  req_valid    in   1   request present
//  req_ready    out  1   responder can accept; handshake = req_valid & req_ready
//  req_we       in   1   1 = store, 0 = load
//  req_addr     in   32  byte address
//  req_wdata    in   32  store data; the relevant bits are in the low lanes (byte [7:0], half [15:0])
//  req_dmtype   in   3   000 word, 001 half, 010 half unsigned, 011 byte, 100 byte unsigned
//  rsp_valid    out  1   one-cycle pulse: response valid
//  rsp_rdata    out  32  load result, extended to 32 bits; 0 for stores and errors
//  rsp_err      out  1   valid with rsp_valid: access rejected
// BEHAVIOUR
//  Reset (rstn=0 at an edge): state=IDLE, rsp_valid=0, rsp_err=0, rsp_rdata=0, wait counter=0.
//   - Any in-flight access is dropped; a pending store is NOT written.
//   - The memory array is not cleared.
//   - req_ready=0 while rstn=0.
//  FSM: IDLE -> ACCESS -> RESP -> IDLE.
//   IDLE:   req_ready=1. On handshake, capture we/addr/wdata/dmtype; cnt<=WAIT_CYCLES; go ACCESS.
//   ACCESS: req_ready=0.
//           - cnt!=0: cnt<=cnt-1.
//           - cnt==0: execute the access at this edge and go RESP.
//   RESP:   rsp_valid=1 for exactly one cycle, req_ready=0; next state IDLE.
//  Timing and input capture:
//   - Latency: handshake in cycle N -> rsp_valid in cycle N+WAIT_CYCLES+2.
//   - One outstanding request only. Next handshake is possible no earlier than the cycle after RESP.
//   - Inputs are sampled only at the handshake edge; later changes are ignored.
//  Error check (at the execute edge; priority order, first match wins):
//   - dmtype in 101..111 -> err
//   - addr outside [BASE_ADDR, BASE_ADDR + 4*2**ADDR_WIDTH - 1] -> err
//   - word with addr[1:0]!=0, or half with addr[0]!=0 -> err
//   - On err: no array write, rsp_rdata=0, rsp_err=1.
//  Index = (addr-BASE_ADDR)>>2. Lane = addr[1:0] for bytes, addr[1] for halves.
//  Stores (no err):
//   - Word: replaces the whole word.
//   - Half: replaces bits [16*addr[1] +: 16] with wdata[15:0].
//   - Byte: replaces bits [8*addr[1:0] +: 8] with wdata[7:0].
//   - All other bits of the word are preserved.
//   - rsp_rdata=0, rsp_err=0.
//  Loads (no err):
//   - Select the lane, then sign-extend (000/001/011) or zero-extend (010/100); word returns as-is.
//  Outputs are registered. rsp_rdata/rsp_err hold their values after RESP until the next RESP or reset.
//  rsp_err is only meaningful while rsp_valid=1.
// TESTING
//  T1 reset, WAIT=2: SW 0x12345678 @0x10 (handshake cycle 0) -> rsp_valid only in cycle 4, err=0;
//     req_ready=0 in cycles 1-4.
//  T2 SB 0xAB @0x11, then LW @0x10 -> 0x1234AB78. LB @0x11 -> 0xFFFFFFAB. LBU @0x11 -> 0x000000AB.
//  T3 SH 0x8001 @0x12, then LH @0x12 -> 0xFFFF8001. LHU @0x12 -> 0x00008001. Other half of the word unchanged.
//  T4 errors: LW @0x13; SH @0x11; dmtype=3'b110; addr=BASE+4*2**ADDR_WIDTH -> each rsp_err=1, rsp_rdata=0;
//     no word is modified (check by LW).
//  T5 rstn=0 during ACCESS of SW 0xDEADBEEF @0x20 -> no rsp_valid; LW @0x20 after reset returns the
//     old value; req_ready=1 the first cycle after reset is released.
//  T6 WAIT=0: back-to-back requests with req_valid held high -> handshakes every 3 cycles;
//     each rsp_valid is a 1-cycle pulse.

Source files
------------

// File: rtl/dm_responder.sv
// Data-memory responder: handshaked multi-cycle memory with wait states,
// DMType-driven store merging, load extension and access error flagging.
module dm_responder #(
  parameter int unsigned ADDR_WIDTH  = 7,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_dmtype,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam logic [32:0] SPAN  = 33'(DEPTH) << 2;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state, next_state;
  logic [3:0]  cnt;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  dmtype_q;

  logic [31:0] mem [DEPTH];

  logic                  handshake;
  logic                  execute;
  logic [31:0]           offset;
  logic [ADDR_WIDTH-1:0] idx;
  logic [31:0]           word_rd;
  logic [15:0]           half_sel;
  logic [7:0]            byte_sel;
  logic                  type_bad, range_bad, align_bad, err;
  logic [31:0]           load_data;
  logic [31:0]           merged;

  assign req_ready = rstn && (state == IDLE);
  assign handshake = req_valid && req_ready;
  assign execute   = (state == ACCESS) && (cnt == 4'd0);

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (handshake) next_state = ACCESS;
      ACCESS:  if (cnt == 4'd0) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt      <= 4'd0;
      we_q     <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      dmtype_q <= 3'd0;
    end else if (handshake) begin
      cnt      <= 4'(WAIT_CYCLES);
      we_q     <= req_we;
      addr_q   <= req_addr;
      wdata_q  <= req_wdata;
      dmtype_q <= req_dmtype;
    end else if (state == ACCESS && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Out-of-range addresses still produce an in-bounds index; err blocks their use.
  assign offset   = addr_q - BASE_ADDR;
  assign idx      = offset[ADDR_WIDTH+1:2];
  assign word_rd  = mem[idx];
  assign half_sel = addr_q[1] ? word_rd[31:16] : word_rd[15:0];
  assign byte_sel = word_rd[8*addr_q[1:0] +: 8];

  assign type_bad  = dmtype_q > 3'd4;
  assign range_bad = (addr_q < BASE_ADDR) || ({1'b0, offset} >= SPAN);
  assign align_bad = ((dmtype_q == 3'd0) && (addr_q[1:0] != 2'd0)) ||
                     (((dmtype_q == 3'd1) || (dmtype_q == 3'd2)) && addr_q[0]);
  assign err       = type_bad || range_bad || align_bad;

  always_comb begin
    load_data = 32'd0;
    case (dmtype_q)
      3'd0:    load_data = word_rd;
      3'd1:    load_data = {{16{half_sel[15]}}, half_sel};
      3'd2:    load_data = {16'd0, half_sel};
      3'd3:    load_data = {{24{byte_sel[7]}}, byte_sel};
      3'd4:    load_data = {24'd0, byte_sel};
      default: load_data = 32'd0;
    endcase
  end

  always_comb begin
    merged = word_rd;
    case (dmtype_q)
      3'd0:       merged = wdata_q;
      3'd1, 3'd2: merged[16*addr_q[1] +: 16] = wdata_q[15:0];
      3'd3, 3'd4: merged[8*addr_q[1:0] +: 8] = wdata_q[7:0];
      default:    merged = word_rd;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstn && execute && we_q && !err) mem[idx] <= merged;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= execute;
      if (execute) begin
        rsp_err   <= err;
        rsp_rdata <= (err || we_q) ? 32'd0 : load_data;
      end
    end
  end

endmodule

// File: tb/tb_dm_responder.sv
// Directed self-checking bench for dm_responder: one instance with two wait
// states and one with none for the back-to-back throughput scenario.
module tb_dm_responder;

  logic        clk;
  logic        rstn, rstn0;
  logic        req_valid, req_valid0;
  logic        req_ready, req_ready0;
  logic        req_we, req_we0;
  logic [31:0] req_addr, req_addr0;
  logic [31:0] req_wdata, req_wdata0;
  logic [2:0]  req_dmtype, req_dmtype0;
  logic        rsp_valid, rsp_valid0;
  logic [31:0] rsp_rdata, rsp_rdata0;
  logic        rsp_err, rsp_err0;

  int checks = 0;
  int fails  = 0;

  dm_responder #(.ADDR_WIDTH(7), .BASE_ADDR(32'h0), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_dmtype(req_dmtype), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err)
  );

  dm_responder #(.ADDR_WIDTH(7), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rstn(rstn0), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_we(req_we0), .req_addr(req_addr0), .req_wdata(req_wdata0),
    .req_dmtype(req_dmtype0), .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0),
    .rsp_err(rsp_err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one request on the selected instance and waits for its response.
  // lat is the response cycle relative to the handshake cycle, -1 on timeout.
  task automatic transact(input bit sel, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [2:0] dt,
                          output logic [31:0] rdata, output logic err, output int lat);
    int guard;
    @(negedge clk);
    if (sel) begin
      req_valid0 = 1'b1; req_we0 = we; req_addr0 = addr; req_wdata0 = wdata; req_dmtype0 = dt;
    end else begin
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_dmtype = dt;
    end
    guard = 0;
    while (!(sel ? req_ready0 : req_ready) && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    lat = -1;
    rdata = 32'hx;
    err = 1'bx;
    if (guard < 20) begin
      @(negedge clk);
      // Scramble inputs after the handshake; the DUT must have captured them already.
      if (sel) begin
        req_valid0 = 1'b0; req_we0 = ~we; req_addr0 = 32'hFFFF_FFFF; req_wdata0 = ~wdata; req_dmtype0 = 3'b111;
      end else begin
        req_valid = 1'b0; req_we = ~we; req_addr = 32'hFFFF_FFFF; req_wdata = ~wdata; req_dmtype = 3'b111;
      end
      lat = 1;
      while (!(sel ? rsp_valid0 : rsp_valid) && lat < 40) begin
        @(negedge clk);
        lat++;
      end
      if (lat >= 40) lat = -1;
      else begin
        rdata = sel ? rsp_rdata0 : rsp_rdata;
        err   = sel ? rsp_err0 : rsp_err;
      end
    end else begin
      if (sel) req_valid0 = 1'b0;
      else     req_valid  = 1'b0;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; rstn0 = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_dmtype = 3'd0;
    req_valid0 = 1'b0; req_we0 = 1'b0; req_addr0 = 32'd0; req_wdata0 = 32'd0; req_dmtype0 = 3'd0;
    repeat (3) @(negedge clk);
    checks++;
    if (req_ready !== 1'b0) begin fails++; $display("[TB] FAIL reset_ready: got %b expected 0", req_ready); end
    checks++;
    if (rsp_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    checks++;
    if (rsp_rdata !== 32'd0) begin fails++; $display("[TB] FAIL reset_rdata: got %h expected 00000000", rsp_rdata); end
    checks++;
    if (rsp_err !== 1'b0) begin fails++; $display("[TB] FAIL reset_err: got %b expected 0", rsp_err); end
    rstn = 1'b1; rstn0 = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin fails++; $display("[TB] FAIL post_reset_ready: got %b expected 1", req_ready); end
    checks++;
    if (req_ready0 !== 1'b1) begin fails++; $display("[TB] FAIL post_reset_ready0: got %b expected 1", req_ready0); end
  endtask

  task automatic test_latency();
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin fails++; $display("[TB] FAIL t1_ready_c0: got %b expected 1", req_ready); end
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h1234_5678; req_dmtype = 3'd0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) begin req_valid = 1'b0; req_addr = 32'h0; req_wdata = 32'hFFFF_FFFF; end
      checks++;
      if (rsp_valid !== (c == 4)) begin
        fails++; $display("[TB] FAIL t1_rsp_valid_c%0d: got %b expected %b", c, rsp_valid, (c == 4));
      end
      checks++;
      if (req_ready !== (c == 5)) begin
        fails++; $display("[TB] FAIL t1_ready_c%0d: got %b expected %b", c, req_ready, (c == 5));
      end
      if (c == 4) begin
        checks++;
        if (rsp_err !== 1'b0 || rsp_rdata !== 32'd0) begin
          fails++; $display("[TB] FAIL t1_store_rsp: got err=%b rdata=%h expected err=0 rdata=00000000", rsp_err, rsp_rdata);
        end
      end
    end
  endtask

  task automatic test_byte();
    logic [31:0] rd; logic er; int lat;
    transact(0, 1'b1, 32'h11, 32'h1234_56AB, 3'd3, rd, er, lat);
    checks++;
    if (lat !== 4 || er !== 1'b0) begin fails++; $display("[TB] FAIL t2_sb: got lat=%0d err=%b expected lat=4 err=0", lat, er); end
    transact(0, 1'b0, 32'h10, 32'h0, 3'd0, rd, er, lat);
    checks++;
    if (rd !== 32'h1234_AB78 || er !== 1'b0) begin fails++; $display("[TB] FAIL t2_lw: got %h err=%b expected 1234ab78 err=0", rd, er); end
    transact(0, 1'b0, 32'h11, 32'h0, 3'd3, rd, er, lat);
    checks++;
    if (rd !== 32'hFFFF_FFAB || lat !== 4) begin fails++; $display("[TB] FAIL t2_lb: got %h lat=%0d expected ffffffab lat=4", rd, lat); end
    transact(0, 1'b0, 32'h11, 32'h0, 3'd4, rd, er, lat);
    checks++;
    if (rd !== 32'h0000_00AB) begin fails++; $display("[TB] FAIL t2_lbu: got %h expected 000000ab", rd); end
    transact(0, 1'b0, 32'h13, 32'h0, 3'd3, rd, er, lat);
    checks++;
    if (rd !== 32'h0000_0012) begin fails++; $display("[TB] FAIL t2_lb_lane3: got %h expected 00000012", rd); end
  endtask

  task automatic test_half();
    logic [31:0] rd; logic er; int lat;
    transact(0, 1'b1, 32'h12, 32'hCDEF_8001, 3'd1, rd, er, lat);
    checks++;
    if (er !== 1'b0 || rd !== 32'd0) begin fails++; $display("[TB] FAIL t3_sh: got err=%b rdata=%h expected err=0 rdata=00000000", er, rd); end
    transact(0, 1'b0, 32'h12, 32'h0, 3'd1, rd, er, lat);
    checks++;
    if (rd !== 32'hFFFF_8001) begin fails++; $display("[TB] FAIL t3_lh: got %h expected ffff8001", rd); end
    transact(0, 1'b0, 32'h12, 32'h0, 3'd2, rd, er, lat);
    checks++;
    if (rd !== 32'h0000_8001) begin fails++; $display("[TB] FAIL t3_lhu: got %h expected 00008001", rd); end
    transact(0, 1'b0, 32'h10, 32'h0, 3'd2, rd, er, lat);
    checks++;
    if (rd !== 32'h0000_AB78) begin fails++; $display("[TB] FAIL t3_lhu_low: got %h expected 0000ab78", rd); end
    transact(0, 1'b0, 32'h10, 32'h0, 3'd1, rd, er, lat);
    checks++;
    if (rd !== 32'hFFFF_AB78) begin fails++; $display("[TB] FAIL t3_lh_low: got %h expected ffffab78", rd); end
    transact(0, 1'b0, 32'h10, 32'h0, 3'd0, rd, er, lat);
    checks++;
    if (rd !== 32'h8001_AB78) begin fails++; $display("[TB] FAIL t3_lw: got %h expected 8001ab78", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat;
    transact(0, 1'b1, 32'h0, 32'hCAFE_F00D, 3'd0, rd, er, lat);
    transact(0, 1'b1, 32'h1FC, 32'h1122_3344, 3'd0, rd, er, lat);
    checks++;
    if (er !== 1'b0) begin fails++; $display("[TB] FAIL t4_sw_last_word: got err=%b expected 0", er); end
    transact(0, 1'b0, 32'h1FC, 32'h0, 3'd0, rd, er, lat);
    checks++;
    if (rd !== 32'h1122_3344 || er !== 1'b0) begin fails++; $display("[TB] FAIL t4_lw_last_word: got %h err=%b expected 11223344 err=0", rd, er); end
    transact(0, 1'b0, 32'h13, 32'h0, 3'd0, rd, er, lat);
    checks++;
    if (er !== 1'b1 || rd !== 32'd0) begin fails++; $display("[TB] FAIL t4_lw_misaligned: got err=%b rdata=%h expected err=1 rdata=00000000", er, rd); end
    transact(0, 1'b1, 32'h11, 32'h0000_5555, 3'd1, rd, er, lat);
    checks++;
    if (er !== 1'b1 || rd !== 32'd0) begin fails++; $display("[TB] FAIL t4_sh_misaligned: got err=%b rdata=%h expected err=1 rdata=00000000", er, rd); end
    transact(0, 1'b1, 32'h10, 32'h9999_9999, 3'b110, rd, er, lat);
    checks++;
    if (er !== 1'b1 || rd !== 32'd0) begin fails++; $display("[TB] FAIL t4_bad_type_store: got err=%b rdata=%h expected err=1 rdata=00000000", er, rd); end
    transact(0, 1'b0, 32'h10, 32'h0, 3'b110, rd, er, lat);
    checks++;
    if (er !== 1'b1 || rd !== 32'd0) begin fails++; $display("[TB] FAIL t4_bad_type_load: got err=%b rdata=%h expected err=1 rdata=00000000", er, rd); end
    transact(0, 1'b1, 32'h200, 32'h7777_7777, 3'd0, rd, er, lat);
    checks++;
    if (er !== 1'b1 || rd !== 32'd0) begin fails++; $display("[TB] FAIL t4_out_of_range: got err=%b rdata=%h expected err=1 rdata=00000000", er, rd); end
    transact(0, 1'b0, 32'h10, 32'h0, 3'd0, rd, er, lat);
    checks++;
    if (rd !== 32'h8001_AB78) begin fails++; $display("[TB] FAIL t4_word10_intact: got %h expected 8001ab78", rd); end
    transact(0, 1'b0, 32'h0, 32'h0, 3'd0, rd, er, lat);
    checks++;
    if (rd !== 32'hCAFE_F00D) begin fails++; $display("[TB] FAIL t4_word0_intact: got %h expected cafef00d", rd); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd; logic er; int lat;
    transact(0, 1'b1, 32'h20, 32'h0BAD_F00D, 3'd0, rd, er, lat);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hDEAD_BEEF; req_dmtype = 3'd0;
    @(negedge clk);
    req_valid = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0) begin fails++; $display("[TB] FAIL t5_ready_in_reset: got %b expected 0", req_ready); end
    rstn = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 0) begin
        checks++;
        if (req_ready !== 1'b1) begin fails++; $display("[TB] FAIL t5_ready_after_reset: got %b expected 1", req_ready); end
      end
      checks++;
      if (rsp_valid !== 1'b0) begin fails++; $display("[TB] FAIL t5_no_rsp_c%0d: got %b expected 0", c, rsp_valid); end
    end
    transact(0, 1'b0, 32'h20, 32'h0, 3'd0, rd, er, lat);
    checks++;
    if (rd !== 32'h0BAD_F00D || er !== 1'b0) begin fails++; $display("[TB] FAIL t5_old_value: got %h err=%b expected 0badf00d err=0", rd, er); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er; int lat;
    @(negedge clk);
    checks++;
    if (req_ready0 !== 1'b1 || rsp_valid0 !== 1'b0) begin
      fails++; $display("[TB] FAIL t6_idle: got ready=%b rsp_valid=%b expected ready=1 rsp_valid=0", req_ready0, rsp_valid0);
    end
    req_valid0 = 1'b1; req_we0 = 1'b1; req_addr0 = 32'h4; req_wdata0 = 32'h0000_0042; req_dmtype0 = 3'd0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      checks++;
      if (req_ready0 !== (c % 3 == 0)) begin
        fails++; $display("[TB] FAIL t6_ready_c%0d: got %b expected %b", c, req_ready0, (c % 3 == 0));
      end
      checks++;
      if (rsp_valid0 !== (c % 3 == 2)) begin
        fails++; $display("[TB] FAIL t6_rsp_valid_c%0d: got %b expected %b", c, rsp_valid0, (c % 3 == 2));
      end
    end
    @(negedge clk);
    req_valid0 = 1'b0;
    repeat (3) @(negedge clk);
    transact(1, 1'b0, 32'h4, 32'h0, 3'd0, rd, er, lat);
    checks++;
    if (rd !== 32'h0000_0042 || lat !== 2 || er !== 1'b0) begin
      fails++; $display("[TB] FAIL t6_load: got %h lat=%0d err=%b expected 00000042 lat=2 err=0", rd, lat, er);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_byte();
    test_half();
    test_errors();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
